// File: rtl/top_nco.sv
// Numerically controlled oscillator: 32-bit phase accumulator feeding a
// quarter-wave sine ROM, producing one registered 8-bit offset-binary sample per clock.
module top_nco (
  input  logic        clk_top,
  input  logic        rst_top,
  input  logic [31:0] NCO_in,
  output logic [7:0]  NCO_out
);

  logic [31:0] phase;
  logic [7:0]  addr;
  logic [6:0]  rom_idx;
  logic [6:0]  rom_q;
  logic [7:0]  sample;

  // 256-point phase; the low 24 bits are dropped without dithering.
  assign addr = phase[31:24];

  // Odd quadrants run the quarter table backwards; a[5:0] == 0 there selects Q[64].
  always_comb begin
    rom_idx = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
  end

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    rom_q = 7'd0;
    case (rom_idx)
      7'd0:  rom_q = 7'd0;    7'd1:  rom_q = 7'd3;    7'd2:  rom_q = 7'd6;
      7'd3:  rom_q = 7'd9;    7'd4:  rom_q = 7'd12;   7'd5:  rom_q = 7'd16;
      7'd6:  rom_q = 7'd19;   7'd7:  rom_q = 7'd22;   7'd8:  rom_q = 7'd25;
      7'd9:  rom_q = 7'd28;   7'd10: rom_q = 7'd31;   7'd11: rom_q = 7'd34;
      7'd12: rom_q = 7'd37;   7'd13: rom_q = 7'd40;   7'd14: rom_q = 7'd43;
      7'd15: rom_q = 7'd46;   7'd16: rom_q = 7'd49;   7'd17: rom_q = 7'd51;
      7'd18: rom_q = 7'd54;   7'd19: rom_q = 7'd57;   7'd20: rom_q = 7'd60;
      7'd21: rom_q = 7'd63;   7'd22: rom_q = 7'd65;   7'd23: rom_q = 7'd68;
      7'd24: rom_q = 7'd71;   7'd25: rom_q = 7'd73;   7'd26: rom_q = 7'd76;
      7'd27: rom_q = 7'd78;   7'd28: rom_q = 7'd81;   7'd29: rom_q = 7'd83;
      7'd30: rom_q = 7'd85;   7'd31: rom_q = 7'd88;   7'd32: rom_q = 7'd90;
      7'd33: rom_q = 7'd92;   7'd34: rom_q = 7'd94;   7'd35: rom_q = 7'd96;
      7'd36: rom_q = 7'd98;   7'd37: rom_q = 7'd100;  7'd38: rom_q = 7'd102;
      7'd39: rom_q = 7'd104;  7'd40: rom_q = 7'd106;  7'd41: rom_q = 7'd107;
      7'd42: rom_q = 7'd109;  7'd43: rom_q = 7'd111;  7'd44: rom_q = 7'd112;
      7'd45: rom_q = 7'd113;  7'd46: rom_q = 7'd115;  7'd47: rom_q = 7'd116;
      7'd48: rom_q = 7'd117;  7'd49: rom_q = 7'd118;  7'd50: rom_q = 7'd120;
      7'd51: rom_q = 7'd121;  7'd52: rom_q = 7'd122;  7'd53: rom_q = 7'd122;
      7'd54: rom_q = 7'd123;  7'd55: rom_q = 7'd124;  7'd56: rom_q = 7'd125;
      7'd57: rom_q = 7'd125;  7'd58: rom_q = 7'd126;  7'd59: rom_q = 7'd126;
      7'd60: rom_q = 7'd126;  7'd61: rom_q = 7'd127;  7'd62: rom_q = 7'd127;
      7'd63: rom_q = 7'd127;  7'd64: rom_q = 7'd127;
      default: rom_q = 7'd0;
    endcase
  end

  // Upper half-cycle is the positive lobe; lower half mirrors it below midscale.
  assign sample = addr[7] ? (8'd128 - {1'b0, rom_q}) : (8'd128 + {1'b0, rom_q});

  // NOTE: state registers use non-blocking assignments so the output sees the pre-update phase.
  always_ff @(posedge clk_top) begin
    if (rst_top) begin
      phase   <= 32'd0;
      NCO_out <= 8'd128;
    end else begin
      phase   <= phase + NCO_in;
      NCO_out <= sample;
    end
  end

endmodule

// File: tb/tb_top_nco.sv
// Self-checking bench for top_nco: vector table for hand-derived sequences plus a
// real-arithmetic sine model feeding a scoreboard queue for the long runs.
module tb_top_nco;

  localparam real PI = 3.14159265358979323846;

  logic        clk_top;
  logic        rst_top;
  logic [31:0] NCO_in;
  logic [7:0]  NCO_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_phase;
  logic [7:0]  exp_q[$];
  logic [7:0]  ramp[1:260];

  typedef struct {
    logic        rst;
    logic [31:0] f;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  top_nco dut (
    .clk_top (clk_top),
    .rst_top (rst_top),
    .NCO_in  (NCO_in),
    .NCO_out (NCO_out)
  );

  initial clk_top = 1'b0;
  always #5 clk_top = ~clk_top;

  // Direct evaluation of round-half-away(127*sin(2*pi*a/256)) over the whole circle.
  function automatic logic [7:0] f_ref(input logic [31:0] p);
    real ang, s, m;
    int  q;
    ang = 2.0 * PI * real'(p[31:24]) / 256.0;
    s   = 127.0 * $sin(ang);
    m   = (s < 0.0) ? -s : s;
    q   = int'($floor(m + 0.5));
    if (s < 0.0) q = -q;
    return 8'(128 + q);
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Advance the reference phase for one edge and return the sample that edge must produce.
  task automatic model_step(input logic rst, input logic [31:0] f, output logic [7:0] exp);
    if (rst) begin
      exp     = 8'd128;
      m_phase = 32'd0;
    end else begin
      exp     = f_ref(m_phase);
      m_phase = m_phase + f;
    end
  endtask

  // One clock: drive inputs, queue the expectation, sample #1 after the edge and compare.
  task automatic drive(input string name, input logic rst, input logic [31:0] f,
                       input logic [7:0] exp, output logic [7:0] got);
    rst_top = rst;
    NCO_in  = f;
    exp_q.push_back(exp);
    @(posedge clk_top);
    #1;
    got = NCO_out;
    check(name, got, exp_q.pop_front());
  endtask

  task automatic run_model(input string name, input logic rst, input logic [31:0] f);
    logic [7:0] e, g;
    model_step(rst, f, e);
    drive(name, rst, f, e, g);
  endtask

  initial begin
    logic [7:0] e, g;
    logic [31:0] f;

    rst_top = 1'b1;
    NCO_in  = 32'd0;
    m_phase = 32'd0;

    // Zero frequency, then quarter-cycle stepping with a reset dropped in mid-run.
    vecs.push_back('{1'b1, 32'h0000_0000, 8'd128});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 32'h0000_0000, 8'd128});
    vecs.push_back('{1'b1, 32'h1234_5678, 8'd128});
    vecs.push_back('{1'b0, 32'h4000_0000, 8'd128});
    vecs.push_back('{1'b0, 32'h4000_0000, 8'd255});
    vecs.push_back('{1'b0, 32'h4000_0000, 8'd128});
    vecs.push_back('{1'b1, 32'h4000_0000, 8'd128});
    vecs.push_back('{1'b0, 32'h4000_0000, 8'd128});
    vecs.push_back('{1'b0, 32'h4000_0000, 8'd255});
    vecs.push_back('{1'b0, 32'h4000_0000, 8'd128});
    vecs.push_back('{1'b0, 32'h4000_0000, 8'd1});
    vecs.push_back('{1'b0, 32'h4000_0000, 8'd128});
    vecs.push_back('{1'b0, 32'h4000_0000, 8'd255});
    vecs.push_back('{1'b0, 32'h4000_0000, 8'd128});
    vecs.push_back('{1'b0, 32'h4000_0000, 8'd1});

    foreach (vecs[i]) begin
      model_step(vecs[i].rst, vecs[i].f, e);
      drive($sformatf("vec%0d", i), vecs[i].rst, vecs[i].f, vecs[i].exp, g);
    end

    // One table step per clock: full circle plus a few, checked against the model.
    run_model("ramp_rst", 1'b1, 32'h0100_0000);
    for (int n = 1; n <= 260; n++) begin
      model_step(1'b0, 32'h0100_0000, e);
      drive($sformatf("ramp%0d", n), 1'b0, 32'h0100_0000, e, g);
      ramp[n] = g;
    end
    check("ramp_first",  ramp[1],   8'd128);
    check("ramp_q1",     ramp[2],   8'd131);
    check("ramp_q15",    ramp[16],  8'd174);
    check("ramp_peak",   ramp[65],  8'd255);
    check("ramp_mid",    ramp[129], 8'd128);
    check("ramp_trough", ramp[193], 8'd1);
    check("ramp_period", ramp[257], 8'd128);

    // Non-power-of-two step: a runs 0, 15, 31, 47, 63, ...
    run_model("odd_rst", 1'b1, 32'd268435450);
    for (int n = 1; n <= 100; n++)
      run_model($sformatf("odd%0d", n), 1'b0, 32'd268435450);

    // All-ones word: the accumulator wraps and the phase walks backwards.
    run_model("dec_rst", 1'b1, 32'hFFFF_FFFF);
    for (int n = 1; n <= 40; n++)
      run_model($sformatf("dec%0d", n), 1'b0, 32'hFFFF_FFFF);

    // Frequency changes without reset must keep the phase continuous.
    run_model("chg_rst", 1'b1, 32'h0000_0000);
    for (int n = 1; n <= 30; n++) run_model($sformatf("chgA%0d", n), 1'b0, 32'h0123_4567);
    for (int n = 1; n <= 30; n++) run_model($sformatf("chgB%0d", n), 1'b0, 32'h3000_0000);
    for (int n = 1; n <= 30; n++) run_model($sformatf("chgC%0d", n), 1'b0, 32'h0080_0000);

    // Random words held for random spans, with an occasional reset.
    for (int blk = 0; blk < 20; blk++) begin
      f = $urandom;
      for (int n = 0; n < int'($urandom_range(12, 3)); n++)
        run_model($sformatf("rnd%0d_%0d", blk, n), ($urandom_range(15, 0) == 0), f);
    end

    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
